// File: rtl/uart_tx_engine.sv
// uart_tx_engine: byte FIFO feeding a programmable-baud UART serialiser (start, 8 data LSB first, [parity], 1-2 stop).
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_data,
  input  logic [31:0] DATA_R,
  input  logic [31:0] CONFIG_R,
  input  logic [31:0] BAUD_DIV,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // state | meaning: IDLE wait for data | START start bit | DATA 8 bits LSB first | PARITY parity bit | STOP 1-2 stop bits
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          overflow_q;

  state_t        state_q;
  logic          tx_q;
  logic          tx_done_q;
  logic [31:0]   baud_cnt_q;
  logic [31:0]   div_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic          two_stop_q;
  logic          stop_second_q;
`ifdef UART_TX_PARITY_EN
  logic          par_en_q;
  logic          par_bit_q;
`endif

  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          bit_end;
  logic          frame_end;
  logic [31:0]   eff_div;
  logic [7:0]    head;

  logic          unused_cfg;
`ifdef UART_TX_PARITY_EN
  assign unused_cfg = ^{DATA_R[31:8], CONFIG_R[31:4]};
`else
  assign unused_cfg = ^{DATA_R[31:8], CONFIG_R[31:4], CONFIG_R[2:1]};
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign eff_div    = (BAUD_DIV == 32'd0) ? 32'd1 : BAUD_DIV;

  assign bit_end    = (baud_cnt_q == div_q - 32'd1);
  assign frame_end  = (state_q == S_STOP) && bit_end && (!two_stop_q || stop_second_q);

  // A pop frees a slot on the same edge, so a write into a full FIFO is still taken then.
  assign pop  = CONFIG_R[0] && !fifo_empty && ((state_q == S_IDLE) || frame_end);
  assign push = new_data && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DATA_R[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      if (new_data && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_q          <= 1'b1;
      tx_done_q     <= 1'b0;
      baud_cnt_q    <= '0;
      div_q         <= 32'd1;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      two_stop_q    <= 1'b0;
      stop_second_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      if (pop) begin
        // Frame settings are frozen here; later CONFIG_R/BAUD_DIV writes wait for the next frame.
        shift_q       <= head;
        div_q         <= eff_div;
        two_stop_q    <= CONFIG_R[3];
        stop_second_q <= 1'b0;
        bit_idx_q     <= '0;
        baud_cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
        par_en_q      <= CONFIG_R[1];
        par_bit_q     <= (^head) ^ CONFIG_R[2];
`endif
        state_q       <= S_START;
        tx_q          <= 1'b0;
        tx_done_q     <= frame_end;
      end else if (state_q != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt_q <= baud_cnt_q + 32'd1;
        end else begin
          baud_cnt_q <= '0;
          case (state_q)
            S_START: begin
              state_q <= S_DATA;
              tx_q    <= shift_q[0];
            end
            S_DATA: begin
              if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                if (par_en_q) begin
                  state_q <= S_PARITY;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
                end
`else
                state_q <= S_STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
                shift_q   <= {1'b0, shift_q[7:1]};
                tx_q      <= shift_q[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
`endif
            S_STOP: begin
              tx_q <= 1'b1;
              if (two_stop_q && !stop_second_q) begin
                stop_second_q <= 1'b1;
              end else begin
                state_q   <= S_IDLE;
                tx_done_q <= 1'b1;
              end
            end
            default: begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign tx       = tx_q;
  assign tx_done  = tx_done_q;
  assign busy     = (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule
